// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch types, constants and a saturating-add helper
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered fetch buffer of {pc, instr} entries with single-cycle flush
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: in-order instruction fetch with credit-limited imem requests and redirect flush.
// Defining FETCH_PERF_CNT_EN adds saturating perf_fetched/perf_flushed/perf_stall counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter int                    MAX_OUTST  = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_flushed,
    output logic [31:0]           perf_stall
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic                  active, gnt, keep, drop, push, pop, empty, full;
    logic [CW-1:0]         count;
    logic [OW-1:0]         outstanding, outst_next, discard;
    logic [ADDR_WIDTH-1:0] pc_q, resp_pc, target;
    entry_t                head;

    assign target      = redirect_pc & ~ADDR_WIDTH'(3);
    // Credits use registered counts only, so every granted response has a free slot
    assign imem_req    = active && !redirect_valid
                         && (int'(count) + int'(outstanding) < DEPTH)
                         && (int'(outstanding) < MAX_OUTST);
    assign imem_addr   = pc_q;
    assign gnt         = imem_req && imem_gnt;
    assign keep        = imem_rvalid && discard == '0;
    assign drop        = imem_rvalid && discard != '0;
    assign push        = keep && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign outst_next  = outstanding + OW'(gnt) - OW'(imem_rvalid);
    assign instr_valid = !empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active      <= 1'b0;
            pc_q        <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            active      <= 1'b1;
            outstanding <= outst_next;
            if (redirect_valid) begin
                pc_q    <= target;
                resp_pc <= target;
                // everything still in flight after this edge belongs to the old stream
                discard <= outst_next;
            end else begin
                if (gnt) pc_q <= pc_q + ADDR_WIDTH'(4);
                if (push) resp_pc <= resp_pc + ADDR_WIDTH'(4);
                if (drop) discard <= discard - OW'(1);
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push && !full),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ('{pc: resp_pc, instr: imem_rdata}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flush_inc;

    assign flush_inc = redirect_valid ? 32'(count) + 32'(imem_rvalid) : 32'(drop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= sat_add(perf_fetched, 32'(pop));
            perf_flushed <= sat_add(perf_flushed, flush_inc);
            perf_stall   <= sat_add(perf_stall, 32'(!instr_valid && !redirect_valid));
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench driving an in-order variable-latency imem model.
// Covers FETCH_PERF_CNT_EN counters when the macro is defined.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
        .perf_stall     (perf_stall)
`endif
    );

    typedef struct { logic [31:0] addr; int epoch; longint due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    req_t        pending[$];
    exp_t        exp_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];
    longint      pop_cyc[$];
    int          checks, failures, epoch, n_pops, stale_cnt;
    int          gnt_pct = 100, gnt_cap = 1000, lat_min = 1, lat_max = 1;
    longint      cyc, last_due, rel_cyc;
    logic [31:0] req_pc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // One clock cycle: memory model drives inputs, scoreboard checks and updates.
    task automatic cycle();
        req_t   r;
        longint due;
        #1;
        imem_rvalid = 1'b0;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = data_of(pending[0].addr);
        end
        imem_gnt = ($urandom_range(0, 99) < gnt_pct) && (exp_q.size() + pending.size() < gnt_cap);
        #1;
        checks++;
        if (instr_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL valid cyc=%0d got=%b want=%b", cyc, instr_valid, exp_q.size() != 0);
        end
        if (instr_valid === 1'b1 && exp_q.size() != 0) begin
            checks++;
            if (instr_pc !== exp_q[0].pc || instr !== exp_q[0].data) begin
                failures++;
                $display("FAIL head cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                         cyc, instr_pc, instr, exp_q[0].pc, exp_q[0].data);
            end
        end
        if (redirect_valid) begin
            checks++;
            if (imem_req !== 1'b0) begin
                failures++;
                $display("FAIL req_during_redirect cyc=%0d got=%b want=0", cyc, imem_req);
            end
        end
        if (imem_req === 1'b1 && imem_gnt) begin
            checks++;
            if (imem_addr !== req_pc) begin
                failures++;
                $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, imem_addr, req_pc);
            end
            due = cyc + longint'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pending.push_back('{imem_addr, epoch, due});
            gnt_log.push_back(imem_addr);
            req_pc = req_pc + 32'd4;
        end
        if (instr_valid === 1'b1 && instr_ready && !redirect_valid && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            pop_log.push_back(instr_pc);
            pop_cyc.push_back(cyc);
            n_pops++;
        end
        if (imem_rvalid) begin
            r = pending.pop_front();
            if (r.epoch != epoch) stale_cnt++;
            else if (!redirect_valid) exp_q.push_back('{r.addr, data_of(r.addr)});
        end
        if (redirect_valid) begin
            exp_q.delete();
            epoch++;
            req_pc = redirect_pc & ~32'd3;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        pending.delete(); exp_q.delete(); gnt_log.delete(); pop_log.delete(); pop_cyc.delete();
        epoch++; n_pops = 0; stale_cnt = 0; req_pc = '0; last_due = cyc;
        gnt_pct = 100; gnt_cap = 1000; lat_min = 1; lat_max = 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_pending(input int n);
        int k = 0;
        while (pending.size() < n && k < 20) begin cycle(); k++; end
        checks++;
        if (pending.size() < n) begin
            failures++;
            $display("FAIL wait_pending got=%0d want=%0d", pending.size(), n);
        end
    endtask

    task automatic test_reset();
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b addr=%h valid=%b instr=%h pc=%h want 0,0,0,0,0",
                     imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetched !== 0 || perf_flushed !== 0 || perf_stall !== 0) begin
            failures++;
            $display("FAIL reset_perf got %0d %0d %0d want 0 0 0", perf_fetched, perf_flushed, perf_stall);
        end
`endif
    endtask

    task automatic test_stream();
        apply_reset();
        instr_ready = 1'b1;
        repeat (10) cycle();
        checks++;
        if (gnt_log.size() < 3 || gnt_log[0] !== 32'h0 || gnt_log[1] !== 32'h4 || gnt_log[2] !== 32'h8) begin
            failures++;
            $display("FAIL stream_addr got n=%0d want 0,4,8", gnt_log.size());
        end
        checks++;
        if (pop_log.size() < 3 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8) begin
            failures++;
            $display("FAIL stream_pc got n=%0d want 0,4,8", pop_log.size());
        end
        checks++;
        if (pop_cyc.size() < 3 || pop_cyc[0] != rel_cyc + 3 || pop_cyc[1] != pop_cyc[0] + 1 || pop_cyc[2] != pop_cyc[1] + 1) begin
            failures++;
            $display("FAIL stream_timing got first=%0d want=%0d consecutive",
                     pop_cyc.size() > 0 ? pop_cyc[0] - rel_cyc : -1, 3);
        end
    endtask

    task automatic test_full();
        apply_reset();
        repeat (12) cycle();
        checks++;
        if (imem_req !== 1'b0 || gnt_log.size() != 4 || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_stop got req=%b grants=%0d valid=%b want 0,4,1", imem_req, gnt_log.size(), instr_valid);
        end
        instr_ready = 1'b1;
        repeat (4) cycle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pop_log.size() <= i || pop_log[i] !== 32'(i * 4)) begin
                failures++;
                $display("FAIL full_drain idx=%0d got=%h want=%h", i, pop_log.size() > i ? pop_log[i] : 'x, i * 4);
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        instr_ready = 1'b1; lat_min = 3; lat_max = 3;
        wait_pending(2);
        redirect_pc = 32'h100; redirect_valid = 1'b1;
        pop_log.delete(); stale_cnt = 0;
        cycle();
        redirect_valid = 1'b0;
        repeat (12) cycle();
        checks++;
        if (stale_cnt != 2) begin
            failures++;
            $display("FAIL redirect_dropped got=%0d want=2", stale_cnt);
        end
        checks++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h100) begin
            failures++;
            $display("FAIL redirect_first_pc got=%h want=00000100", pop_log.size() > 0 ? pop_log[0] : 'x);
        end
    endtask

    task automatic test_redirect_collision();
        apply_reset();
        instr_ready = 1'b1;
        repeat (6) cycle();
        checks++;
        if (instr_valid !== 1'b1 || pending.size() != 1) begin
            failures++;
            $display("FAIL collide_setup got valid=%b pending=%0d want 1,1", instr_valid, pending.size());
        end
        redirect_pc = 32'h200; redirect_valid = 1'b1;
        pop_log.delete();
        cycle();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL collide_after got valid=%b req=%b addr=%h want 0,1,00000200", instr_valid, imem_req, imem_addr);
        end
        repeat (6) cycle();
        checks++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h200) begin
            failures++;
            $display("FAIL collide_first_pc got=%h want=00000200", pop_log.size() > 0 ? pop_log[0] : 'x);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        instr_ready = 1'b1; lat_min = 3; lat_max = 3;
        wait_pending(2);
        stale_cnt = 0; pop_log.delete();
        redirect_pc = 32'h300; redirect_valid = 1'b1;
        cycle();
        redirect_pc = 32'h400;
        cycle();
        redirect_valid = 1'b0;
        repeat (15) cycle();
        checks++;
        if (stale_cnt != 2 || pop_log.size() == 0 || pop_log[0] !== 32'h400) begin
            failures++;
            $display("FAIL b2b got stale=%0d first=%h want 2,00000400", stale_cnt, pop_log.size() > 0 ? pop_log[0] : 'x);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        instr_ready = 1'b1;
        repeat (3) cycle();
        redirect_pc = 32'hFFFF_FFFF; redirect_valid = 1'b1;
        gnt_log.delete(); pop_log.delete();
        cycle();
        redirect_valid = 1'b0;
        repeat (6) cycle();
        checks++;
        if (gnt_log.size() < 2 || gnt_log[0] !== 32'hFFFF_FFFC || gnt_log[1] !== 32'h0) begin
            failures++;
            $display("FAIL wrap_addr got n=%0d want FFFFFFFC,00000000", gnt_log.size());
        end
        checks++;
        if (pop_log.size() < 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc got n=%0d want FFFFFFFC,00000000", pop_log.size());
        end
    endtask

    task automatic test_random();
        apply_reset();
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            instr_ready    = $urandom_range(0, 9) < 7;
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_pc    = $urandom;
            cycle();
        end
        redirect_valid = 1'b0;
        checks++;
        if (n_pops < 20) begin
            failures++;
            $display("FAIL random_progress got=%0d want>=20", n_pops);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        instr_ready = 1'b0; lat_min = 2; lat_max = 2;
        repeat (5) cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid got req=%b valid=%b addr=%h want 0,0,0", imem_req, instr_valid, imem_addr);
        end
        apply_reset();
        instr_ready = 1'b1;
        repeat (8) cycle();
        checks++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_first got=%h want=0", pop_log.size() > 0 ? pop_log[0] : 'x);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        int k = 0;
        apply_reset();
        gnt_cap = 3;
        while (!(n_pops == 10 && exp_q.size() == 3 && pending.size() == 0) && k < 100) begin
            instr_ready = n_pops < 10;
            cycle();
            k++;
        end
        instr_ready = 1'b0;
        redirect_pc = 32'h80; redirect_valid = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (perf_fetched !== 32'd10 || perf_flushed !== 32'd3) begin
            failures++;
            $display("FAIL perf got fetched=%0d flushed=%0d want 10,3", perf_fetched, perf_flushed);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_collision();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
